// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0033;
    localparam int          INSTR_BYTES = 4;

    // One buffered fetch result: the instruction and the PC it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Small circular buffer of {pc, instr} entries between the imem response and decode.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t          mem [BUF_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage and pointers; reset loads NOP entries so the head reads NOP/pc 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '{pc: 32'h0, instr: NOP_INSTR};
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: PC ownership, credit-based imem issue, redirect/halt handling.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_instr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic        o_idle
);

    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int CW1 = CW + 1;

    fetch_state_t  state, state_nxt;
    logic [31:0]   pc;
    logic          inflight_vld;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW1-1:0] occ;

    // Next state, credit check and handshake decode; redirect beats pop and issue.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        issue     = 1'b0;
        occ       = '0;
        case (state)
            S_RESET: state_nxt = S_RUN;
            S_RUN:   if (i_halt)  state_nxt = S_HALT;
            S_HALT:  if (!i_halt) state_nxt = S_RUN;
            default: state_nxt = S_RESET;
        endcase
        pop  = (count != '0) && i_ready && !i_redirect;
        push = inflight_vld && !i_redirect;
        // Counting this cycle's pop lets depth 2 stream one instruction per cycle.
        occ   = {1'b0, count} + CW1'(inflight_vld) - CW1'(pop);
        issue = (state == S_RUN) && !i_halt && !i_redirect && (occ < CW1'(BUF_DEPTH));
    end

    // PC, FSM and the single in-flight request tracker.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= S_RESET;
            pc           <= RESET_PC;
            inflight_vld <= 1'b0;
            inflight_pc  <= 32'h0;
        end else begin
            state        <= state_nxt;
            inflight_vld <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (i_redirect) begin
                pc <= i_redirect_pc & ~32'd3;
            end else if (issue) begin
                pc <= pc + 32'(INSTR_BYTES);
            end
        end
    end

    assign wr_entry = '{pc: inflight_pc, instr: i_imem_instr};

    if_fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_redirect),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign o_imem_req  = issue;
    assign o_imem_addr = pc;
    assign o_valid     = (count != '0);
    assign o_instr     = head.instr;
    assign o_pc        = head.pc;
    assign o_idle      = (state == S_HALT) && !inflight_vld && (count == '0);

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch controller for the IF stage: owns the program counter, issues sequential read requests to the instruction memory, and absorbs the memory's fixed one-cycle read latency in a small instruction/PC buffer. It presents instructions to decode with a valid/ready handshake. It handles redirects from branch/jump resolution and a halt request, discarding wrong-path fetches. It sits between `if_instrMem` (downstream on the address side) and the IF/ID boundary.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, 2: instruction buffer entries (≥2).
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  synchronous active-low reset.
- `o_imem_req`  out  1  address valid this cycle.
- `o_imem_addr`  out  32  fetch address, word-aligned.
- `i_imem_instr`  in  32  instruction for the address requested in the previous cycle.
- `o_valid`  out  1  `o_instr`/`o_pc` valid to decode.
- `i_ready`  in  1  decode accepts; pop when `o_valid & i_ready`.
- `o_instr`  out  32  instruction at buffer head.
- `o_pc`  out  32  PC of `o_instr`.
- `i_redirect`  in  1  flush and restart at `i_redirect_pc`.
- `i_redirect_pc`  in  32  new PC; bits [1:0] ignored (forced 0).
- `i_halt`  in  1  stop issuing new requests while high.
- `o_idle`  out  1  halted, nothing in flight, buffer empty.

## Operation
- FSM states: `S_RESET` (first cycle after reset release, no request), `S_RUN`, `S_HALT`.
- Transitions:
  - `S_RESET`→`S_RUN`.
  - `S_RUN`→`S_HALT` when `i_halt`.
  - `S_HALT`→`S_RUN` when `!i_halt`.
- Credit rule: issue when `S_RUN`, `!i_redirect`, and occupancy + in_flight − pop < `BUF_DEPTH`. Pop is counted in the same cycle, so depth 2 sustains one instruction per cycle.
- On issue: `o_imem_addr` = pc, pc ← pc + 4 (mod 2^32, wraps silently). The issued PC is held in an in-flight register with a valid bit.
- Response: the cycle after issue, `i_imem_instr` and the in-flight PC are pushed into the buffer, unless the request was killed.
- Redirect (any state):
  - pc ← `{i_redirect_pc[31:2],2'b00}`.
  - Buffer flushed.
  - In-flight response killed (not pushed).
  - No request in the redirect cycle.
  - A pop in the same cycle is ignored: redirect wins.
  - A redirect while halted loads pc and the FSM stays `S_HALT`.
- Halt: in-flight response still lands and the buffer still drains; only new issue stops.
- `o_imem_addr` holds pc when `o_imem_req`=0.

## Timing
- Reset values:
  - pc = `RESET_PC`, FSM `S_RESET`.
  - `o_imem_req`=0, `o_imem_addr`=`RESET_PC`.
  - `o_valid`=0, `o_instr`=32'h0000_0033 (NOP), `o_pc`=0.
  - buffer empty, in-flight invalid, `o_idle`=0.
- First request is in cycle 1 after reset release (cycle 0 = `S_RESET`).
- Latency from issue to `o_valid` is 2 cycles: push at the end of issue+1, visible at issue+2. No bypass.
- Redirect penalty: redirect in cycle N, request at the new PC in N+1, `o_valid` for it in N+3.
- Outputs `o_valid`/`o_instr`/`o_pc` are taken from the buffer head registers only (no combinational path from `i_imem_instr`).
- `o_valid` holds with stable data until popped, redirected or reset.
- Buffer full: push never occurs because credit prevents over-issue.
- Reset asserted mid-operation: all state returns to reset values at that edge. Any in-flight response is dropped.

## Structure
- Package `if_pkg`:
  - `fetch_state_t` enum.
  - `NOP_INSTR` = 32'h0000_0033.
  - `INSTR_BYTES` = 4.
- Sub-module `if_fetch_fifo`: parametric `BUF_DEPTH` FIFO of {pc, instr}, with synchronous flush, push/pop, and count output.

## Test plan
- Reset release, `i_ready`=1, memory returns addr+0x100:
  - requests at 0, 4, 8, … each cycle;
  - `o_valid` first in cycle 3 with `o_pc`=0, `o_instr`=0x100;
  - one instruction per cycle thereafter.
- `i_ready`=0 from cycle 3 for 5 cycles:
  - at most 2 entries buffered, `o_imem_req` drops;
  - on release, PCs continue 0, 4, 8 with no gap or duplicate.
- Redirect to 0x0000_0052 in cycle 6 with an entry in flight:
  - killed entry never appears;
  - next request addr 0x0000_0050 in cycle 7, `o_pc`=0x50 valid in cycle 9.
- `i_halt`=1 mid-stream with `i_ready`=1:
  - issue stops, in-flight and buffered entries drain;
  - `o_idle`=1 two cycles later;
  - deassert → fetch resumes at the next sequential PC.
- Redirect and pop in the same cycle, and redirect to 0xFFFF_FFFC: buffer flushed, sequence 0xFFFF_FFFC then 0x0000_0000.
- `i_rst_n`=0 for one cycle mid-stream: all outputs at reset values next cycle, refetch from `RESET_PC`.
